// File: rtl/nfa_router.sv
// Front end for an array of NFA processing elements: input FIFO, sliding character
// window broadcast to the PEs, per-PE config registers and a tagged result pipeline.
module nfa_router #(
    parameter int DWIDTH     = 8,
    parameter int NUM        = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PE_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DWIDTH-1:0]       in_char,
    input  logic                    in_last,
    input  logic                    cfg_we,
    input  logic [$clog2(NUM)-1:0]  cfg_idx,
    input  logic                    cfg_alu,
    input  logic                    cfg_en,
    output logic                    cfg_err,
    output logic [NUM-1:0]          ALU_to_pe,
    output logic [NUM-1:0]          en_to_pe,
    output logic [NUM*DWIDTH-1:0]   str_to_pe,
    output logic                    pe_valid,
    input  logic [NUM-1:0]          result_from_pe,
    output logic                    res_valid,
    output logic [NUM-1:0]          result,
    output logic                    res_any,
    output logic [31:0]             res_pos,
    output logic                    res_last,
    output logic                    busy
);
    localparam int IDX_W = $clog2(NUM);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W:0] NUM_LIM = (IDX_W+1)'(NUM);
    localparam logic [CNT_W-1:0] DEPTH_LIM = CNT_W'(FIFO_DEPTH);

    // FIFO storage holds {last, char}
    logic [DWIDTH:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 push, pop;
    logic [DWIDTH:0]      head;

    logic [DWIDTH-1:0]    win_reg [NUM];
    logic                 prev_last_reg;
    logic [31:0]          next_pos_reg;

    logic [PE_LAT:0]      pipe_valid_reg;
    logic [31:0]          pipe_pos_reg [PE_LAT+1];
    logic [PE_LAT:0]      pipe_last_reg;

    logic                 res_valid_reg, res_any_reg, res_last_reg, cfg_err_reg;
    logic [NUM-1:0]       result_reg;
    logic [31:0]          res_pos_reg;
    logic [NUM-1:0]       alu_reg, en_reg, alu_next, en_next, cfg_sel;
    logic                 cfg_ok;

    assign in_ready = (count_reg < DEPTH_LIM);
    assign push     = in_valid && in_ready;
    assign pop      = (count_reg != '0);
    assign head     = fifo_mem[rd_ptr_reg];
    assign busy     = pop || (|pipe_valid_reg);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {in_last, in_char};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    // Window shift; a preceding end-of-string clears the history behind the new char
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM; i++) win_reg[i] <= '0;
            prev_last_reg <= 1'b0;
            next_pos_reg  <= '0;
        end else if (pop) begin
            win_reg[0] <= head[DWIDTH-1:0];
            for (int i = 1; i < NUM; i++)
                win_reg[i] <= prev_last_reg ? '0 : win_reg[i-1];
            prev_last_reg <= head[DWIDTH];
            next_pos_reg  <= head[DWIDTH] ? 32'd0 : next_pos_reg + 32'd1;
        end
    end

    // Stage 0 is aligned with the window, so its valid bit doubles as pe_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid_reg <= '0;
            pipe_last_reg  <= '0;
            for (int i = 0; i <= PE_LAT; i++) pipe_pos_reg[i] <= '0;
        end else begin
            pipe_valid_reg[0] <= pop;
            pipe_last_reg[0]  <= head[DWIDTH];
            pipe_pos_reg[0]   <= next_pos_reg;
            for (int i = 1; i <= PE_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_last_reg[i]  <= pipe_last_reg[i-1];
                pipe_pos_reg[i]   <= pipe_pos_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            result_reg    <= '0;
            res_any_reg   <= 1'b0;
            res_pos_reg   <= '0;
            res_last_reg  <= 1'b0;
        end else begin
            res_valid_reg <= pipe_valid_reg[PE_LAT];
            if (pipe_valid_reg[PE_LAT]) begin
                result_reg   <= result_from_pe & en_reg;
                res_any_reg  <= |(result_from_pe & en_reg);
                res_pos_reg  <= pipe_pos_reg[PE_LAT];
                res_last_reg <= pipe_last_reg[PE_LAT];
            end
        end
    end

    // Config writes only land while the array is idle and the index exists
    always_comb begin
        cfg_sel  = {{(NUM-1){1'b0}}, 1'b1} << cfg_idx;
        cfg_ok   = cfg_we && !busy && ({1'b0, cfg_idx} < NUM_LIM);
        alu_next = alu_reg;
        en_next  = en_reg;
        if (cfg_ok) begin
            alu_next = cfg_alu ? (alu_reg | cfg_sel) : (alu_reg & ~cfg_sel);
            en_next  = cfg_en  ? (en_reg  | cfg_sel) : (en_reg  & ~cfg_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_reg     <= '0;
            en_reg      <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            alu_reg     <= alu_next;
            en_reg      <= en_next;
            cfg_err_reg <= cfg_we && !cfg_ok;
        end
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : g_slice
        assign str_to_pe[gi*DWIDTH +: DWIDTH] = win_reg[gi];
    end

    assign pe_valid  = pipe_valid_reg[0];
    assign res_valid = res_valid_reg;
    assign result    = result_reg;
    assign res_any   = res_any_reg;
    assign res_pos   = res_pos_reg;
    assign res_last  = res_last_reg;
    assign ALU_to_pe = alu_reg;
    assign en_to_pe  = en_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_nfa_router.sv
// Directed bench for nfa_router: config vector table plus hand-written stream,
// window-reset, busy-config and mid-stream reset sequences.
module tb_nfa_router;
    localparam int DW = 8;
    localparam int N  = 12;
    localparam int FD = 4;
    localparam int PL = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [DW-1:0]   in_char = '0;
    logic            cfg_we = 1'b0, cfg_alu = 1'b0, cfg_en = 1'b0, cfg_err;
    logic [3:0]      cfg_idx = '0;
    logic [N-1:0]    ALU_to_pe, en_to_pe, result, result_from_pe = '0;
    logic [N*DW-1:0] str_to_pe;
    logic            pe_valid, res_valid, res_any, res_last, busy;
    logic [31:0]     res_pos;

    nfa_router #(.DWIDTH(DW), .NUM(N), .FIFO_DEPTH(FD), .PE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_alu(cfg_alu), .cfg_en(cfg_en),
        .cfg_err(cfg_err), .ALU_to_pe(ALU_to_pe), .en_to_pe(en_to_pe),
        .str_to_pe(str_to_pe), .pe_valid(pe_valid), .result_from_pe(result_from_pe),
        .res_valid(res_valid), .result(result), .res_any(res_any), .res_pos(res_pos),
        .res_last(res_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [N*DW-1:0] str; int cyc; } pe_ev_t;
    typedef struct { logic [N-1:0] result; logic any; logic [31:0] pos; logic last; int cyc; } res_ev_t;
    pe_ev_t  pe_q[$];
    res_ev_t res_q[$];

    always @(negedge clk) begin
        if (pe_valid)  pe_q.push_back('{str_to_pe, cyc});
        if (res_valid) res_q.push_back('{result, res_any, res_pos, res_last, cyc});
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] c, input logic l);
        in_valid = 1'b1;
        in_char  = c;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        chk("drain_timeout", busy, 1'b0);
        tick();
        tick();
    endtask

    typedef struct {
        logic we; logic [3:0] idx; logic alu; logic en;
        logic [N-1:0] exp_alu; logic [N-1:0] exp_en; logic exp_err;
    } cfg_vec_t;
    cfg_vec_t vecs [8];

    initial begin
        logic [N*DW-1:0] e;
        int n0;

        vecs[0] = '{1'b1, 4'd3,  1'b1, 1'b1, 12'h008, 12'h008, 1'b0};
        vecs[1] = '{1'b1, 4'd12, 1'b1, 1'b1, 12'h008, 12'h008, 1'b1};
        vecs[2] = '{1'b0, 4'd5,  1'b1, 1'b1, 12'h008, 12'h008, 1'b0};
        vecs[3] = '{1'b1, 4'd0,  1'b0, 1'b1, 12'h008, 12'h009, 1'b0};
        vecs[4] = '{1'b1, 4'd15, 1'b1, 1'b1, 12'h008, 12'h009, 1'b1};
        vecs[5] = '{1'b1, 4'd3,  1'b0, 1'b1, 12'h000, 12'h009, 1'b0};
        vecs[6] = '{1'b1, 4'd11, 1'b1, 1'b0, 12'h800, 12'h009, 1'b0};
        vecs[7] = '{1'b1, 4'd0,  1'b0, 1'b0, 12'h800, 12'h008, 1'b0};

        // reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu", ALU_to_pe, '0);
        chk("rst_en", en_to_pe, '0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_res_pos", res_pos, '0);
        chk("rst_pe_valid", pe_valid, 1'b0);
        chk("rst_str", str_to_pe, '0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // config table
        for (int i = 0; i < 8; i++) begin
            cfg_we = vecs[i].we; cfg_idx = vecs[i].idx;
            cfg_alu = vecs[i].alu; cfg_en = vecs[i].en;
            tick();
            cfg_we = 1'b0;
            chk($sformatf("cfg%0d_alu", i), ALU_to_pe, vecs[i].exp_alu);
            chk($sformatf("cfg%0d_en", i), en_to_pe, vecs[i].exp_en);
            chk($sformatf("cfg%0d_err", i), cfg_err, vecs[i].exp_err);
        end

        // "abc" with all PEs matching; only enabled PE 3 survives the mask
        result_from_pe = 12'hFFF;
        pe_q.delete(); res_q.delete();
        n0 = cyc;
        push("a", 1'b0); push("b", 1'b0); push("c", 1'b1);
        drain();
        chk("abc_pe_cnt", pe_q.size(), 3);
        if (pe_q.size() == 3) begin
            chk("abc_pe_lat", pe_q[0].cyc, n0 + 2);
            e = '0; e[7:0] = "b"; e[15:8] = "a";
            chk("abc_win1", pe_q[1].str, e);
            e = '0; e[7:0] = "c"; e[15:8] = "b"; e[23:16] = "a";
            chk("abc_win2", pe_q[2].str, e);
        end
        chk("abc_res_cnt", res_q.size(), 3);
        if (res_q.size() == 3) begin
            chk("abc_res_lat", res_q[0].cyc, n0 + 4);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("abc_pos%0d", i), res_q[i].pos, i);
                chk($sformatf("abc_last%0d", i), res_q[i].last, (i == 2));
                chk($sformatf("abc_result%0d", i), res_q[i].result, 12'h008);
                chk($sformatf("abc_any%0d", i), res_q[i].any, 1'b1);
            end
        end
        chk("hold_valid", res_valid, 1'b0);
        chk("hold_result", result, 12'h008);
        chk("hold_pos", res_pos, 32'd2);
        chk("hold_last", res_last, 1'b1);

        // six back-to-back chars, no PE matches
        result_from_pe = 12'h000;
        pe_q.delete(); res_q.delete();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b2b_ready%0d", i), in_ready, 1'b1);
            push(8'h30 + 8'(i), (i == 5));
        end
        drain();
        chk("b2b_res_cnt", res_q.size(), 6);
        if (res_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("b2b_pos%0d", i), res_q[i].pos, i);
                chk($sformatf("b2b_any%0d", i), res_q[i].any, 1'b0);
                if (i > 0) chk($sformatf("b2b_cyc%0d", i), res_q[i].cyc, res_q[i-1].cyc + 1);
            end
        end

        // "xy"(last) then "z": window and position restart after end of string
        result_from_pe = 12'h00C;
        pe_q.delete(); res_q.delete();
        push("x", 1'b0); push("y", 1'b1); push("z", 1'b1);
        drain();
        chk("xyz_pe_cnt", pe_q.size(), 3);
        if (pe_q.size() == 3) begin
            e = '0; e[7:0] = "x";
            chk("xyz_win0", pe_q[0].str, e);
            e = '0; e[7:0] = "y"; e[15:8] = "x";
            chk("xyz_win1", pe_q[1].str, e);
            e = '0; e[7:0] = "z";
            chk("xyz_win2", pe_q[2].str, e);
        end
        chk("xyz_res_cnt", res_q.size(), 3);
        if (res_q.size() == 3) begin
            chk("xyz_pos0", res_q[0].pos, 0);
            chk("xyz_pos1", res_q[1].pos, 1);
            chk("xyz_pos2", res_q[2].pos, 0);
            chk("xyz_result", res_q[2].result, 12'h008);
        end

        // config write while busy is rejected
        push("q", 1'b1);
        chk("busy_cfg_busy", busy, 1'b1);
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_alu = 1'b1; cfg_en = 1'b1;
        tick();
        cfg_we = 1'b0;
        chk("busy_cfg_err", cfg_err, 1'b1);
        chk("busy_cfg_en", en_to_pe, 12'h008);
        chk("busy_cfg_alu", ALU_to_pe, 12'h800);
        tick();
        chk("busy_cfg_err_pulse", cfg_err, 1'b0);
        drain();

        // one-cycle reset in the middle of a stream
        push("m", 1'b0); push("n", 1'b0); push("o", 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_pe_valid", pe_valid, 1'b0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_en", en_to_pe, '0);
        chk("mid_rst_str", str_to_pe, '0);
        rst_n = 1'b1;
        pe_q.delete(); res_q.delete();
        repeat (10) tick();
        chk("mid_rst_no_pe", pe_q.size(), 0);
        chk("mid_rst_no_res", res_q.size(), 0);
        chk("mid_rst_idle", busy, 1'b0);

        // first char after reset tags position 0
        push("k", 1'b1);
        drain();
        chk("post_rst_cnt", res_q.size(), 1);
        if (res_q.size() == 1) begin
            chk("post_rst_pos", res_q[0].pos, 0);
            chk("post_rst_result", res_q[0].result, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nfa_router.md
NFA_ROUTER -- requirements
Module: nfa_router

Interface
REQ-001 Parameters SHALL be: DWIDTH, default 8, character width; NUM, default 16, PE count (>=2); FIFO_DEPTH, default 4, input FIFO entries (power of 2, >=2); PE_LAT, default 1, PE result latency in cycles (>=1).
REQ-002 Ports SHALL be, clock and reset first:
clk  in  1  sole clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
in_valid  in  1  input character valid
in_ready  out  1  FIFO can accept
in_char  in  DWIDTH  input character
in_last  in  1  last character of current string
cfg_we  in  1  PE config write strobe
cfg_idx  in  $clog2(NUM)  target PE index
cfg_alu  in  1  ALU mode bit for target PE
cfg_en  in  1  enable bit for target PE
cfg_err  out  1  one-cycle pulse: write rejected
ALU_to_pe  out  NUM  per-PE ALU mode
en_to_pe  out  NUM  per-PE enable
str_to_pe  out  NUM*DWIDTH  sliding window; slice i = character i positions back
pe_valid  out  1  window valid strobe to PEs
result_from_pe  in  NUM  per-PE match bits
res_valid  out  1  result strobe
result  out  NUM  masked match vector
res_any  out  1  OR of result
res_pos  out  32  byte index of character that produced result
res_last  out  1  result belongs to last character of string
busy  out  1  FIFO non-empty or result pipeline occupied

Function
REQ-003 Input handshake: a character SHALL be accepted on any cycle with in_valid && in_ready; in_ready SHALL be high exactly when FIFO count < FIFO_DEPTH (registered count, no combinational path from in_valid).
REQ-004 Pop: on every cycle FIFO is non-empty, the head entry SHALL be popped; push and pop in the same cycle SHALL leave count unchanged.
REQ-005 Window: on pop, slice 0 SHALL load the popped char and slice i SHALL load old slice i-1 (i=1..NUM-1); if the previous popped char had last=1, slices 1..NUM-1 SHALL load 0 instead.
REQ-006 pe_valid SHALL be high for exactly one cycle, the cycle after each pop; latency in_valid accept -> pe_valid is 2 cycles minimum.
REQ-007 Position: res_pos tag SHALL equal 0 for the first char after reset or after a last char, incrementing by 1 per pop, wrapping 2^32-1 -> 0.
REQ-008 Result: result_from_pe SHALL be sampled PE_LAT cycles after the corresponding pe_valid; the next cycle res_valid SHALL be 1, result = sample & en_to_pe, res_any = |result, res_pos/res_last = tag of that char.
REQ-009 Result pipeline SHALL be a PE_LAT+1 deep shift register of {valid,pos,last}; back-to-back pops SHALL yield back-to-back res_valid with no loss; no backpressure exists on result.
REQ-010 Config: when cfg_we && !busy && cfg_idx < NUM, bit cfg_idx of ALU_to_pe/en_to_pe SHALL take cfg_alu/cfg_en next cycle; otherwise, with cfg_we high, no bit SHALL change and cfg_err SHALL pulse next cycle.
REQ-011 result, res_pos, res_last SHALL hold their last values while res_valid is 0.
REQ-012 busy SHALL be combinational OR of FIFO non-empty and any pipeline valid bit.

Reset
REQ-013 With rst_n low at a clock edge, FIFO count, pointers, window, position, last flag, pipeline valids, ALU_to_pe, en_to_pe and all outputs SHALL be 0 next cycle, except in_ready = 1.
REQ-014 Reset mid-stream SHALL discard all FIFO and in-flight data; no res_valid SHALL follow reset release until a new char is accepted.

Verification
REQ-015 Config PE 3 (alu=1,en=1) when idle -> ALU_to_pe=0x0008, en_to_pe=0x0008; cfg_idx=NUM -> cfg_err pulse, registers unchanged.
REQ-016 Stream "abc" (last on c), PE_LAT=1, result_from_pe=0xFFFF -> three pe_valid pulses, slice0/1/2 at third = 'c','b','a'; res_valid x3 with res_pos 0,1,2, res_last only on 2, result=0x0008.
REQ-017 Hold in_valid with pe side idle 6 chars back-to-back -> in_ready never drops (pop rate 1/cycle), 6 consecutive res_valid.
REQ-018 "xy"(last) then "z" -> window for 'z' has slices 1..NUM-1 = 0, res_pos restarts 0.
REQ-019 cfg_we while busy -> cfg_err pulse, no change; rst_n low mid-stream for 1 cycle -> in_ready=1, busy=0, no stale res_valid.
